l1_cache_sa: RTL and testbench
==============================

Name: l1_cache_sa

Overview:
- Parametrised set-associative L1 data cache. Write-back, write-allocate, pseudo-LRU replacement.
- Sits between the pipeline memory stage (word interface) and the L2 cache (128-bit block interface).
- Successor to the direct-mapped L1 cache, with configurable set count and associativity (1/2/4 ways).
- Writeback is followed by a correct refill, and requests are handshaked against L2 ready.

Parameters:
- SET_BITS, 3, log2 of number of sets; index = proc_addr[SET_BITS+1:2].
- WAYS, 2, associativity; legal values 1, 2, 4.
- TAGLEN, 28-SET_BITS, tag width; tag = proc_addr[29:SET_BITS+2].
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- proc_reset_n  in  1  asynchronous active-low reset.
- proc_read  in  1  processor load request.
- proc_write  in  1  processor store request.
- proc_addr  in  30  word address; [1:0] selects word within block.
- proc_wdata  in  32  store data.
- proc_rdata  out  32  load data.
- proc_stall  out  1  processor must hold its request stable while high.
- read  out  1  L2 block read request.
- write  out  1  L2 block write request.
- addr  out  30  L2 block address, [1:0] always 2'b00.
- wdata  out  128  L2 write block.
- rdata  in  128  L2 read block.
- ready  in  1  L2 completion, one-cycle pulse.

Behaviour:
- Reset (proc_reset_n low, async):
  - state=IDLE; all valid, dirty and PLRU bits cleared.
  - Outputs forced to 0: proc_stall, proc_rdata, read, write, addr, wdata.
  - Data/tag arrays need not be cleared.
  - Reset mid-miss abandons the L2 request immediately; read/write drop the same cycle.
- Request handling:
  - proc_read and proc_write together is treated as a write.
  - Neither asserted means idle: no array or PLRU change, all outputs 0.
- Hit (IDLE, tag match on a valid way): zero-latency, proc_stall=0.
  - Read: proc_rdata = selected word, combinational.
  - Write: word merged at the next edge; dirty set.
  - PLRU updated to mark the hit way most recent.
- Miss (IDLE):
  - proc_stall=1 combinationally in the request cycle.
  - Victim selection: lowest-index invalid way, else the PLRU victim.
  - 2 ways: one bit per set. 4 ways: 3-bit tree. 1 way: way 0.
  - Victim dirty -> WRITEBACK; otherwise -> ALLOCATE.
  - read/write assert from the cycle after the miss.
- WRITEBACK:
  - write=1, addr={victim_tag,index,2'b00}, wdata=victim block, proc_stall=1.
  - Held stable until ready.
  - On ready: victim dirty cleared, next state ALLOCATE.
  - No read in the ready cycle.
- ALLOCATE:
  - read=1, addr={tag,index,2'b00}, proc_stall=1 until ready.
  - On ready, at the edge: block written to the victim way; valid=1; tag written; dirty=proc_write.
  - On a write miss, proc_wdata is merged over rdata.
  - PLRU marks the filled way most recent; next state IDLE.
  - In the ready cycle: proc_stall=0, read=0, and for loads proc_rdata = word of rdata.
  - Miss penalty: clean miss = L2 latency + 1 cycle; dirty miss = two L2 transactions + 2 cycles.
- ready outside WRITEBACK/ALLOCATE is ignored.
- The processor holds proc_addr, proc_read, proc_write and proc_wdata stable while proc_stall=1; violation is unsupported.
- A request in the cycle after a refill is a normal lookup and hits the filled line.

Optional Feature:
- L1_PERF_CNT_EN defined:
  - Adds outputs hit_cnt and miss_cnt, CNT_W bits each.
  - hit_cnt increments on each IDLE hit. miss_cnt increments once per miss, in the miss-detect cycle.
  - Both counters wrap at 2^CNT_W and clear on reset.
- Undefined: ports and counters absent; no other behavioural difference.

Test Plan:
- Cold load 0x00000040, L2 ready after 3 cycles with rdata={32'hD,32'hC,32'hB,32'hA} -> read/addr=0x40 held 3 cycles; ready cycle proc_stall=0, proc_rdata=32'hA. Repeat load 0x41 -> hit, proc_rdata=32'hB, no L2 activity.
- Store 0x00000020 data 32'h1234 on a miss -> ALLOCATE, line dirty. Load 0x20 -> hit, 32'h1234.
- WAYS=2: fill 0x00, 0x20, 0x40 (all set 0), where 0x00 is dirty and least recent -> write=1 with addr=0x00 carrying the stored data; then read addr=0x40; 0x20 remains a hit.
- Touch 0x00 after filling 0x00 and 0x20, then miss on 0x40 -> 0x20 evicted; 0x00 still hits.
- Assert proc_reset_n=0 mid-WRITEBACK -> write=0 and proc_stall=0 in the same cycle; after release, load 0x00 misses.
- L1_PERF_CNT_EN: 3 hits + 2 misses -> hit_cnt=3, miss_cnt=2; 65536 hits with CNT_W=16 -> hit_cnt wraps to 0.

Source files
------------

// File: rtl/l1_cache_sa.sv
// l1_cache_sa: parametrised set-associative L1 data cache.
// Write-back, write-allocate, pseudo-LRU replacement (1/2/4 ways).
// Word interface to the pipeline, 128-bit block interface to L2.
//
// Ports:
//   clk, proc_reset_n          clock (rising edge), async active-low reset
//   proc_read/proc_write       processor load/store request (both = store)
//   proc_addr[29:0]            word address, [1:0] = word within block
//   proc_wdata/proc_rdata      store data / load data (load data is combinational)
//   proc_stall                 processor holds its request while high
//   read/write                 L2 block read/write request
//   addr[29:0]                 L2 block address, [1:0] = 2'b00
//   wdata/rdata[127:0]         L2 write block / L2 read block
//   ready                      L2 completion pulse
//   hit_cnt/miss_cnt           performance counters (only with L1_PERF_CNT_EN)
//
// Optional feature macro: L1_PERF_CNT_EN adds the hit/miss counters.
module l1_cache_sa #(
   parameter int unsigned SET_BITS = 3,
   parameter int unsigned WAYS     = 2,
   parameter int unsigned TAGLEN   = 28 - SET_BITS,
   parameter int unsigned CNT_W    = 16
) (
   input  logic          clk,
   input  logic          proc_reset_n,
   input  logic          proc_read,
   input  logic          proc_write,
   input  logic [29:0]   proc_addr,
   input  logic [31:0]   proc_wdata,
   output logic [31:0]   proc_rdata,
   output logic          proc_stall,
   output logic          read,
   output logic          write,
   output logic [29:0]   addr,
   output logic [127:0]  wdata,
   input  logic [127:0]  rdata,
   input  logic          ready
`ifdef L1_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
`endif
);

   localparam int unsigned SETS  = 1 << SET_BITS;
   localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   // Reject unsupported configurations at elaboration.
   if (!(WAYS == 1 || WAYS == 2 || WAYS == 4) || CNT_W == 0 ||
       TAGLEN != 28 - SET_BITS) begin : g_bad_param
      $error("l1_cache_sa: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WRITEBACK = 2'd1,
      S_ALLOCATE  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next_state;

   // Storage: data/tag need no reset, control bits do.
   logic [127:0]      r_data  [SETS][WAYS];
   logic [TAGLEN-1:0] r_tag   [SETS][WAYS];
   logic [WAYS-1:0]   r_valid [SETS];
   logic [WAYS-1:0]   r_dirty [SETS];
   logic [2:0]        r_plru  [SETS];
   logic [WAY_W-1:0]  r_victim;

   logic [SET_BITS-1:0] w_index;
   logic [TAGLEN-1:0]   w_tag;
   logic [1:0]          w_word;
   logic                w_req;
   logic [WAYS-1:0]     w_hit_vec;
   logic [WAY_W-1:0]    w_hit_way;
   logic                w_hit;
   logic [WAY_W-1:0]    w_plru_way;
   logic [WAY_W-1:0]    w_victim_way;
   logic                w_found;
   logic                w_victim_dirty;
   logic                w_idle_hit;
   logic                w_idle_miss;
   logic                w_hit_store;
   logic                w_fill;

   assign w_index = proc_addr[SET_BITS+1:2];
   assign w_tag   = proc_addr[29:SET_BITS+2];
   assign w_word  = proc_addr[1:0];
   assign w_req   = proc_read | proc_write;

   // Mark 'way' most recently used; bits point at the less recent side.
   // 2 ways: bit0 = victim way. 4 ways: bit0 root (0 = left pair),
   // bit1 = victim within {0,1}, bit2 = victim within {2,3}.
   function automatic logic [2:0] plru_touch(input logic [2:0] cur,
                                             input logic [WAY_W-1:0] way);
      logic [2:0] nxt;
      nxt = cur;
      if (WAYS == 2) begin
         nxt[0] = ~way[0];
      end else if (WAYS == 4) begin
         if (!way[WAY_W-1]) begin
            nxt[0] = 1'b1;
            nxt[1] = ~way[0];
         end else begin
            nxt[0] = 1'b0;
            nxt[2] = ~way[0];
         end
      end
      return nxt;
   endfunction

   function automatic logic [127:0] merge_word(input logic [127:0] blk,
                                               input logic [1:0]   sel,
                                               input logic [31:0]  d);
      logic [127:0] res;
      res = blk;
      res[{sel, 5'b0} +: 32] = d;
      return res;
   endfunction

   // Tag compare across all ways of the indexed set.
   always_comb begin
      w_hit_vec = '0;
      w_hit_way = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         if (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
            w_hit_vec[w] = 1'b1;
            w_hit_way    = WAY_W'(w);
         end
      end
   end

   assign w_hit = |w_hit_vec;

   // Victim: lowest-index invalid way, otherwise the PLRU choice.
   always_comb begin
      w_plru_way = '0;
      if (WAYS == 2) begin
         w_plru_way = WAY_W'(r_plru[w_index][0]);
      end else if (WAYS == 4) begin
         if (r_plru[w_index][0]) begin
            w_plru_way = r_plru[w_index][2] ? WAY_W'(3) : WAY_W'(2);
         end else begin
            w_plru_way = r_plru[w_index][1] ? WAY_W'(1) : WAY_W'(0);
         end
      end
      w_victim_way = w_plru_way;
      w_found      = 1'b0;
      for (int w = 0; w < int'(WAYS); w++) begin
         if (!w_found && !r_valid[w_index][w]) begin
            w_victim_way = WAY_W'(w);
            w_found      = 1'b1;
         end
      end
   end

   assign w_victim_dirty = r_valid[w_index][w_victim_way] & r_dirty[w_index][w_victim_way];
   assign w_idle_hit     = (r_state == S_IDLE) && w_req && w_hit;
   assign w_idle_miss    = (r_state == S_IDLE) && w_req && !w_hit;
   assign w_hit_store    = w_idle_hit && proc_write;
   assign w_fill         = (r_state == S_ALLOCATE) && ready;

   // State register.
   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_idle_miss) begin
               w_next_state = w_victim_dirty ? S_WRITEBACK : S_ALLOCATE;
            end
         end
         S_WRITEBACK: begin
            if (ready) begin
               w_next_state = S_ALLOCATE;
            end
         end
         S_ALLOCATE: begin
            if (ready) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Outputs; reset forces everything low even while a miss is pending.
   always_comb begin
      proc_stall = 1'b0;
      proc_rdata = '0;
      read       = 1'b0;
      write      = 1'b0;
      addr       = '0;
      wdata      = '0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               if (w_hit) begin
                  if (!proc_write) begin
                     proc_rdata = r_data[w_index][w_hit_way][{w_word, 5'b0} +: 32];
                  end
               end else begin
                  proc_stall = 1'b1;
               end
            end
         end
         S_WRITEBACK: begin
            proc_stall = 1'b1;
            write      = 1'b1;
            addr       = {r_tag[w_index][r_victim], w_index, 2'b00};
            wdata      = r_data[w_index][r_victim];
         end
         S_ALLOCATE: begin
            if (ready) begin
               if (!proc_write) begin
                  proc_rdata = rdata[{w_word, 5'b0} +: 32];
               end
            end else begin
               proc_stall = 1'b1;
               read       = 1'b1;
               addr       = {proc_addr[29:2], 2'b00};
            end
         end
         default: ;
      endcase
      if (!proc_reset_n) begin
         proc_stall = 1'b0;
         proc_rdata = '0;
         read       = 1'b0;
         write      = 1'b0;
         addr       = '0;
         wdata      = '0;
      end
   end

   // Valid/dirty/PLRU bookkeeping and victim capture.
   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         for (int s = 0; s < int'(SETS); s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            r_plru[s]  <= '0;
         end
         r_victim <= '0;
      end else begin
         if (w_idle_hit) begin
            r_plru[w_index] <= plru_touch(r_plru[w_index], w_hit_way);
            if (proc_write) begin
               r_dirty[w_index][w_hit_way] <= 1'b1;
            end
         end
         if (w_idle_miss) begin
            r_victim <= w_victim_way;
         end
         if ((r_state == S_WRITEBACK) && ready) begin
            r_dirty[w_index][r_victim] <= 1'b0;
         end
         if (w_fill) begin
            r_valid[w_index][r_victim] <= 1'b1;
            r_dirty[w_index][r_victim] <= proc_write;
            r_plru[w_index]            <= plru_touch(r_plru[w_index], r_victim);
         end
      end
   end

   // Data and tag arrays: store hits merge one word, refills write the block.
   always_ff @(posedge clk) begin
      if (w_hit_store) begin
         r_data[w_index][w_hit_way] <= merge_word(r_data[w_index][w_hit_way], w_word, proc_wdata);
      end
      if (w_fill) begin
         r_data[w_index][r_victim] <= proc_write ? merge_word(rdata, w_word, proc_wdata) : rdata;
         r_tag[w_index][r_victim]  <= w_tag;
      end
   end

`ifdef L1_PERF_CNT_EN
   logic [CNT_W-1:0] r_hit_cnt;
   logic [CNT_W-1:0] r_miss_cnt;

   // Free-running wrap-around counters of IDLE hits and detected misses.
   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_idle_hit) begin
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
         end
         if (w_idle_miss) begin
            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
         end
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_l1_cache_sa.sv
// Directed self-checking bench for l1_cache_sa (default SET_BITS=3, WAYS=2).
// Inputs change at the falling edge, outputs are sampled 1 time unit later.
module tb_l1_cache_sa;

   logic          clk;
   logic          proc_reset_n;
   logic          proc_read;
   logic          proc_write;
   logic [29:0]   proc_addr;
   logic [31:0]   proc_wdata;
   logic [31:0]   proc_rdata;
   logic          proc_stall;
   logic          read;
   logic          write;
   logic [29:0]   addr;
   logic [127:0]  wdata;
   logic [127:0]  rdata;
   logic          ready;
`ifdef L1_PERF_CNT_EN
   logic [15:0]   hit_cnt;
   logic [15:0]   miss_cnt;
`endif

   int n_chk;
   int n_err;

   localparam logic [127:0] BLK_A = {32'hD, 32'hC, 32'hB, 32'hA};
   localparam logic [127:0] BLK0  = 128'h00000103_00000102_00000101_00000100;
   localparam logic [127:0] BLK1  = 128'h00000113_00000112_00000111_00000110;
   localparam logic [127:0] BLK2  = 128'h00000123_00000122_00000121_00000120;
   localparam logic [127:0] BLK3  = 128'h00000133_00000132_00000131_00000130;
   localparam logic [127:0] WB0   = 128'h00000103_00000102_00000101_0000CAFE;

   l1_cache_sa dut (
      .clk          (clk),
      .proc_reset_n (proc_reset_n),
      .proc_read    (proc_read),
      .proc_write   (proc_write),
      .proc_addr    (proc_addr),
      .proc_wdata   (proc_wdata),
      .proc_rdata   (proc_rdata),
      .proc_stall   (proc_stall),
      .read         (read),
      .write        (write),
      .addr         (addr),
      .wdata        (wdata),
      .rdata        (rdata),
      .ready        (ready)
`ifdef L1_PERF_CNT_EN
      ,
      .hit_cnt      (hit_cnt),
      .miss_cnt     (miss_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic req(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d);
      proc_read  = rd;
      proc_write = wr;
      proc_addr  = a;
      proc_wdata = d;
   endtask

   task automatic do_reset();
      nxt();
      proc_reset_n = 1'b0;
      req(1'b0, 1'b0, 30'h0, 32'h0);
      ready = 1'b0;
      rdata = '0;
      nxt();
      proc_reset_n = 1'b1;
   endtask

   // Clean miss: request cycle, one L2 read cycle, then ready, then idle.
   task automatic clean_miss(input logic wr, input logic [29:0] a, input logic [31:0] d,
                             input logic [127:0] blk, input logic [31:0] exp_rd, input string tag);
      nxt();
      req(!wr, wr, a, d);
      #1;
      chk({tag, "_miss_stall"}, proc_stall, 1'b1);
      chk({tag, "_miss_read"}, read, 1'b0);
      nxt();
      #1;
      chk({tag, "_alloc_read"}, read, 1'b1);
      chk({tag, "_alloc_addr"}, addr, {a[29:2], 2'b00});
      chk({tag, "_alloc_write"}, write, 1'b0);
      nxt();
      ready = 1'b1;
      rdata = blk;
      #1;
      chk({tag, "_rdy_stall"}, proc_stall, 1'b0);
      chk({tag, "_rdy_read"}, read, 1'b0);
      if (!wr) chk({tag, "_rdy_rdata"}, proc_rdata, exp_rd);
      nxt();
      ready = 1'b0;
      rdata = '0;
      req(1'b0, 1'b0, 30'h0, 32'h0);
   endtask

   initial begin
      n_chk        = 0;
      n_err        = 0;
      proc_reset_n = 1'b0;
      ready        = 1'b0;
      rdata        = '0;
      req(1'b1, 1'b0, 30'h40, 32'h0);

      // Reset holds outputs low even with a pending load.
      #2;
      chk("rst_stall", proc_stall, 1'b0);
      chk("rst_read", read, 1'b0);
      chk("rst_write", write, 1'b0);
      chk("rst_addr", addr, 30'h0);
      chk("rst_wdata", wdata, 128'h0);
      chk("rst_rdata", proc_rdata, 32'h0);

      nxt();
      proc_reset_n = 1'b1;
      req(1'b0, 1'b0, 30'h0, 32'h0);
      #1;
      chk("idle_stall", proc_stall, 1'b0);
      chk("idle_read", read, 1'b0);

      // Cold load 0x40, L2 ready after three read cycles.
      nxt();
      req(1'b1, 1'b0, 30'h40, 32'h0);
      #1;
      chk("cold_stall", proc_stall, 1'b1);
      chk("cold_read0", read, 1'b0);
      for (int i = 0; i < 3; i++) begin
         nxt();
         #1;
         n_chk++;
         if (read !== 1'b1) begin
            n_err++;
            $error("FAIL cold_read[%0d]: observed %0h expected 1", i, read);
         end
         n_chk++;
         if (addr !== 30'h40) begin
            n_err++;
            $error("FAIL cold_addr[%0d]: observed %0h expected 40", i, addr);
         end
         n_chk++;
         if (proc_stall !== 1'b1) begin
            n_err++;
            $error("FAIL cold_hold_stall[%0d]: observed %0h expected 1", i, proc_stall);
         end
      end
      nxt();
      ready = 1'b1;
      rdata = BLK_A;
      #1;
      chk("cold_rdy_stall", proc_stall, 1'b0);
      chk("cold_rdy_read", read, 1'b0);
      chk("cold_rdy_rdata", proc_rdata, 32'hA);
      nxt();
      ready = 1'b0;
      rdata = '0;
      proc_addr = 30'h41;
      #1;
      chk("hit41_stall", proc_stall, 1'b0);
      chk("hit41_rdata", proc_rdata, 32'hB);
      chk("hit41_read", read, 1'b0);
      chk("hit41_write", write, 1'b0);

      // ready in IDLE is ignored.
      nxt();
      req(1'b0, 1'b0, 30'h0, 32'h0);
      ready = 1'b1;
      #1;
      chk("ign_rdy_stall", proc_stall, 1'b0);
      chk("ign_rdy_read", read, 1'b0);
      nxt();
      ready = 1'b0;

      // Store miss 0x20 allocates and merges; then hits and a store hit.
      clean_miss(1'b1, 30'h20, 32'h1234, BLK1, 32'h0, "st20");
      nxt();
      req(1'b1, 1'b0, 30'h20, 32'h0);
      #1;
      chk("ld20_stall", proc_stall, 1'b0);
      chk("ld20_rdata", proc_rdata, 32'h1234);
      nxt();
      proc_addr = 30'h21;
      #1;
      chk("ld21_rdata", proc_rdata, 32'h111);
      nxt();
      req(1'b0, 1'b1, 30'h22, 32'h5555);
      #1;
      chk("st22_stall", proc_stall, 1'b0);
      nxt();
      req(1'b1, 1'b0, 30'h22, 32'h0);
      #1;
      chk("ld22_rdata", proc_rdata, 32'h5555);

      // Dirty LRU victim: writeback of 0x00 then refill of 0x40.
      do_reset();
      clean_miss(1'b1, 30'h00, 32'hCAFE, BLK0, 32'h0, "st00");
      clean_miss(1'b0, 30'h20, 32'h0, BLK1, 32'h110, "ld20");
      nxt();
      req(1'b1, 1'b0, 30'h40, 32'h0);
      #1;
      chk("wbm_stall", proc_stall, 1'b1);
      chk("wbm_write", write, 1'b0);
      nxt();
      #1;
      chk("wb_write", write, 1'b1);
      chk("wb_addr", addr, 30'h00);
      chk("wb_wdata", wdata, WB0);
      chk("wb_read", read, 1'b0);
      chk("wb_stall", proc_stall, 1'b1);
      nxt();
      #1;
      chk("wb_hold_write", write, 1'b1);
      nxt();
      ready = 1'b1;
      #1;
      chk("wb_rdy_write", write, 1'b1);
      chk("wb_rdy_read", read, 1'b0);
      nxt();
      ready = 1'b0;
      #1;
      chk("wb_alloc_write", write, 1'b0);
      chk("wb_alloc_read", read, 1'b1);
      chk("wb_alloc_addr", addr, 30'h40);
      nxt();
      ready = 1'b1;
      rdata = BLK2;
      #1;
      chk("wb_fill_stall", proc_stall, 1'b0);
      chk("wb_fill_rdata", proc_rdata, 32'h120);
      nxt();
      ready = 1'b0;
      rdata = '0;
      proc_addr = 30'h20;
      #1;
      chk("keep20_stall", proc_stall, 1'b0);
      chk("keep20_rdata", proc_rdata, 32'h110);

      // Touching 0x00 makes 0x20 the victim.
      do_reset();
      clean_miss(1'b0, 30'h00, 32'h0, BLK0, 32'h100, "ld00");
      clean_miss(1'b0, 30'h20, 32'h0, BLK1, 32'h110, "ld20b");
      nxt();
      req(1'b1, 1'b0, 30'h00, 32'h0);
      #1;
      chk("touch00_stall", proc_stall, 1'b0);
      chk("touch00_rdata", proc_rdata, 32'h100);
      clean_miss(1'b0, 30'h40, 32'h0, BLK2, 32'h120, "ld40");
      nxt();
      req(1'b1, 1'b0, 30'h03, 32'h0);
      #1;
      chk("still00_stall", proc_stall, 1'b0);
      chk("still00_rdata", proc_rdata, 32'h103);
      nxt();
      proc_addr = 30'h20;
      #1;
      chk("evict20_stall", proc_stall, 1'b1);

      // Reset in the middle of a writeback.
      do_reset();
      clean_miss(1'b1, 30'h00, 32'hCAFE, BLK0, 32'h0, "st00b");
      clean_miss(1'b0, 30'h20, 32'h0, BLK1, 32'h110, "ld20c");
      nxt();
      req(1'b1, 1'b0, 30'h40, 32'h0);
      nxt();
      #1;
      chk("rwb_write", write, 1'b1);
      nxt();
      proc_reset_n = 1'b0;
      #1;
      chk("rwb_rst_write", write, 1'b0);
      chk("rwb_rst_stall", proc_stall, 1'b0);
      chk("rwb_rst_read", read, 1'b0);
      nxt();
      proc_reset_n = 1'b1;
      proc_addr = 30'h00;
      #1;
      chk("rwb_ld00_stall", proc_stall, 1'b1);
      chk("rwb_ld00_write", write, 1'b0);
      nxt();
      #1;
      chk("rwb_alloc_read", read, 1'b1);
      chk("rwb_alloc_write", write, 1'b0);
      chk("rwb_alloc_addr", addr, 30'h00);
      nxt();
      ready = 1'b1;
      rdata = BLK3;
      #1;
      chk("rwb_fill_rdata", proc_rdata, 32'h130);
      nxt();
      ready = 1'b0;
      rdata = '0;
      req(1'b0, 1'b0, 30'h0, 32'h0);

`ifdef L1_PERF_CNT_EN
      // Two misses and three hits.
      do_reset();
      clean_miss(1'b0, 30'h00, 32'h0, BLK0, 32'h100, "pc00");
      clean_miss(1'b0, 30'h20, 32'h0, BLK1, 32'h110, "pc20");
      nxt();
      req(1'b1, 1'b0, 30'h00, 32'h0);
      nxt();
      proc_addr = 30'h01;
      nxt();
      proc_addr = 30'h20;
      nxt();
      req(1'b0, 1'b0, 30'h0, 32'h0);
      #1;
      chk("cnt_hit", hit_cnt, 16'd3);
      chk("cnt_miss", miss_cnt, 16'd2);

      // 65536 hits wrap the 16-bit hit counter.
      do_reset();
      clean_miss(1'b0, 30'h00, 32'h0, BLK0, 32'h100, "pcw");
      nxt();
      req(1'b1, 1'b0, 30'h00, 32'h0);
      repeat (65536) nxt();
      req(1'b0, 1'b0, 30'h0, 32'h0);
      #1;
      chk("cnt_wrap_hit", hit_cnt, 16'd0);
      chk("cnt_wrap_miss", miss_cnt, 16'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
